// File: rtl/int_fp_converter_pipe_if.sv
// Valid/ready bundle between an integer producer, the int-to-float converter
// and its downstream consumer.
interface int_fp_converter_pipe_if #(
    parameter int unsigned INT_W = 16,
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
);

    logic                   in_valid;
    logic                   in_ready;
    logic [INT_W-1:0]       in_int;
    logic                   in_rnd;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_fp;
    logic                   out_inexact;

    modport master (
        output in_valid,
        output in_int,
        output in_rnd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_fp,
        input  out_inexact
    );

    modport slave (
        input  in_valid,
        input  in_int,
        input  in_rnd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_fp,
        output out_inexact
    );

endinterface

// File: rtl/int_fp_converter_pipe.sv
// Three-stage signed-integer to floating-point converter with RNE/truncate
// rounding and a globally stalled valid/ready pipeline.
module int_fp_converter_pipe #(
    parameter int unsigned INT_W = 16,
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    int_fp_converter_pipe_if.slave bus
);

    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned P_W   = $clog2(INT_W);
    localparam int unsigned EXT_W = INT_W + MAN_W + 1;

    // The largest exponent after a rounding carry must stay below all-ones.
    if (INT_W < 2 || INT_W > 32 || (INT_W - 1) + BIAS > (1 << EXP_W) - 2) begin : g_bad_params
        $error("int_fp_converter_pipe: INT_W/EXP_W combination can overflow the exponent");
    end

    logic adv;

    // S1 state
    logic              s1_valid;
    logic              s1_sign;
    logic              s1_rnd;
    logic [INT_W-1:0]  s1_mag;

    // S2 state
    logic              s2_valid;
    logic              s2_sign;
    logic              s2_rnd;
    logic              s2_zero;
    logic [EXP_W-1:0]  s2_exp;
    logic [INT_W-2:0]  s2_frac;

    // S3 / output state
    logic              out_valid_q;
    logic [FP_W-1:0]   out_fp_q;
    logic              out_inexact_q;

    // Combinational intermediates
    logic [INT_W-1:0]  mag_c;
    logic [P_W-1:0]    lead_pos_c;
    logic              lead_found_c;
    logic [P_W-1:0]    shamt_c;
    logic [INT_W-2:0]  frac_c;
    logic [EXP_W-1:0]  exp_c;
    logic [EXT_W-1:0]  ext_c;
    logic [MAN_W-1:0]  mant_c;
    logic              guard_c;
    logic              sticky_c;
    logic              inc_c;
    logic [MAN_W:0]    mant_sum_c;
    logic [EXP_W-1:0]  exp_rnd_c;
    logic [FP_W-1:0]   fp_c;
    logic              inexact_c;

    assign adv             = bus.out_ready || !out_valid_q;
    assign bus.in_ready    = adv;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_fp      = out_fp_q;
    assign bus.out_inexact = out_inexact_q;

    // Unsigned negation keeps the most negative input representable.
    assign mag_c = bus.in_int[INT_W-1] ? (~bus.in_int) + INT_W'(1) : bus.in_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_mag   <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.in_int[INT_W-1];
            s1_rnd   <= bus.in_rnd;
            s1_mag   <= mag_c;
        end
    end

    // Leading-one detect: the highest set bit wins because it is visited last.
    always_comb begin
        lead_pos_c   = '0;
        lead_found_c = 1'b0;
        for (int i = 0; i < int'(INT_W); i++) begin
            if (s1_mag[i]) begin
                lead_pos_c   = P_W'(i);
                lead_found_c = 1'b1;
            end
        end
    end

    assign shamt_c = P_W'(INT_W - 1) - lead_pos_c;
    assign frac_c  = (INT_W-1)'(s1_mag << shamt_c);
    assign exp_c   = EXP_W'(lead_pos_c) + EXP_W'(BIAS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_rnd   <= 1'b0;
            s2_zero  <= 1'b1;
            s2_exp   <= '0;
            s2_frac  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_rnd   <= s1_rnd;
            s2_zero  <= !lead_found_c;
            s2_exp   <= exp_c;
            s2_frac  <= frac_c;
        end
    end

    // Fraction is left-aligned with room for mantissa, guard and sticky bits.
    assign ext_c      = {s2_frac, (MAN_W+2)'(0)};
    assign mant_c     = ext_c[EXT_W-1 -: MAN_W];
    assign guard_c    = ext_c[INT_W];
    assign sticky_c   = |ext_c[INT_W-1:0];
    assign inc_c      = !s2_rnd && guard_c && (sticky_c || mant_c[0]);
    assign mant_sum_c = {1'b0, mant_c} + (MAN_W+1)'(inc_c);
    assign exp_rnd_c  = s2_exp + EXP_W'(mant_sum_c[MAN_W]);
    assign fp_c       = s2_zero ? '0 : {s2_sign, exp_rnd_c, mant_sum_c[MAN_W-1:0]};
    assign inexact_c  = guard_c || sticky_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_fp_q      <= '0;
            out_inexact_q <= 1'b0;
        end else if (adv) begin
            out_valid_q   <= s2_valid;
            out_fp_q      <= fp_c;
            out_inexact_q <= inexact_c;
        end
    end

endmodule
